rv32i_ctrl_alu_dmem: RTL and testbench

// Single-cycle RV32I execute/memory slice: main+ALU decoder, 32-bit ALU and byte-enabled data BRAM in one block.

---
 rtl/rv32i_ctrl_alu_dmem_pkg.sv | 91 +++++++++
 rtl/rv32i_ctrl_alu_dmem_if.sv | 48 ++++
 rtl/rv32i_ctrl_alu_dmem_bram32_be.sv | 35 +++
 rtl/rv32i_ctrl_alu_dmem.sv | 169 ++++++++++++++++
 tb/tb_rv32i_ctrl_alu_dmem.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/rv32i_ctrl_alu_dmem_pkg.sv
// Shared widths, opcodes and control encodings for the RV32I execute/memory slice.
// Pure definitions: no logic, no latency, no flow control.
package rv32i_ctrl_alu_dmem_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 12;
  localparam int DEPTH      = 1024;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } alu_ctrl_e;

  typedef enum logic [2:0] {
    IMM_I = 3'b000,
    IMM_S = 3'b001,
    IMM_B = 3'b010,
    IMM_J = 3'b011,
    IMM_U = 3'b100
  } imm_src_e;

  typedef enum logic [1:0] {
    WB_MEM = 2'b00,
    WB_ALU = 2'b01,
    WB_PC4 = 2'b10,
    WB_U   = 2'b11
  } wb_src_e;

  typedef enum logic [1:0] {
    SEC_AS_NONE  = 2'b00,
    SEC_AS_LUI   = 2'b01,
    SEC_AS_AUIPC = 2'b10,
    SEC_AS_JALR  = 2'b11
  } sec_src_e;

  typedef struct packed {
    logic      cond_br;
    logic      jump;
    imm_src_e  imm_src;
    logic      mem_read;
    logic      mem_write;
    logic      alu_src;
    logic      reg_write;
    logic      mem_2_reg;
    wb_src_e   wb_src;
    sec_src_e  sec_src;
    alu_ctrl_e alu_ctrl;
  } ctrl_t;

  // I-type never subtracts: func7[5] only selects SRAI there.
  function automatic alu_ctrl_e alu_decode(input logic [2:0] f3, input logic f7b5,
                                           input logic is_reg);
    case (f3)
      3'b000:  return (is_reg && f7b5) ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return f7b5 ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  function automatic alu_ctrl_e branch_alu(input logic [2:0] f3);
    case (f3)
      3'b100, 3'b101: return ALU_SLT;
      3'b110, 3'b111: return ALU_SLTU;
      default:        return ALU_SUB;
    endcase
  endfunction

endpackage

// File: rtl/rv32i_ctrl_alu_dmem_if.sv
// Operand, control and memory-port bundle between the core/host and the execute slice.
// Wires only; no latency, no flow control.
interface rv32i_ctrl_alu_dmem_if;
  import rv32i_ctrl_alu_dmem_pkg::*;

  logic [6:0]            opcode;
  logic [2:0]            func3;
  logic [6:0]            func7;
  logic [DATA_WIDTH-1:0] rs1;
  logic [DATA_WIDTH-1:0] rs2;
  logic [DATA_WIDTH-1:0] imm;
  logic [3:0]            byte_enb;
  logic                  init_done;
  logic [ADDR_WIDTH-1:0] h_w_addr;
  logic [DATA_WIDTH-1:0] h_w_dat;
  logic                  h_w_enb;
  logic [3:0]            h_byte_enb;
  logic [ADDR_WIDTH-1:0] debug_addr;

  logic                  branch;
  logic [2:0]            imm_src;
  logic                  mem_read;
  logic                  mem_write;
  logic                  alu_src;
  logic                  reg_write;
  logic                  mem_2_reg;
  logic [1:0]            wrt_back_src;
  logic [1:0]            second_add_src;
  logic [DATA_WIDTH-1:0] alu_result;
  logic                  alu_zero;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic [DATA_WIDTH-1:0] debug_data;

  modport master (
    output opcode, func3, func7, rs1, rs2, imm, byte_enb, init_done,
           h_w_addr, h_w_dat, h_w_enb, h_byte_enb, debug_addr,
    input  branch, imm_src, mem_read, mem_write, alu_src, reg_write, mem_2_reg,
           wrt_back_src, second_add_src, alu_result, alu_zero, mem_rdata, debug_data
  );

  modport slave (
    input  opcode, func3, func7, rs1, rs2, imm, byte_enb, init_done,
           h_w_addr, h_w_dat, h_w_enb, h_byte_enb, debug_addr,
    output branch, imm_src, mem_read, mem_write, alu_src, reg_write, mem_2_reg,
           wrt_back_src, second_add_src, alu_result, alu_zero, mem_rdata, debug_data
  );

endinterface

// File: rtl/rv32i_ctrl_alu_dmem_bram32_be.sv
// Byte-lane-enabled word array: one write port, two combinational read ports.
// Write lands on rising clk, visible on reads the next cycle; no backpressure.
module bram32_be #(
  parameter int DW    = 32,
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            we_i,
  input  logic [DW/8-1:0] be_i,
  input  logic [AW-1:0]   waddr_i,
  input  logic [DW-1:0]   wdat_i,
  input  logic [AW-1:0]   raddr_i,
  output logic [DW-1:0]   rdat_o,
  input  logic [AW-1:0]   dbg_addr_i,
  output logic [DW-1:0]   dbg_dat_o
);

  logic [DW-1:0] mem_q [DEPTH];

  // Contents deliberately have no reset: they survive rst assertion.
  always_ff @(posedge clk) begin
    if (we_i) begin
      for (int k = 0; k < DW/8; k++) begin
        if (be_i[k]) begin
          mem_q[waddr_i][8*k +: 8] <= wdat_i[8*k +: 8];
        end
      end
    end
  end

  assign rdat_o    = mem_q[raddr_i];
  assign dbg_dat_o = mem_q[dbg_addr_i];

endmodule

// File: rtl/rv32i_ctrl_alu_dmem.sv
// Single-cycle RV32I decode + ALU + byte-enabled data memory with host init and debug ports.
// Decode/ALU/reads combinational, writes commit on rising clk; no backpressure.
module rv32i_ctrl_alu_dmem
  import rv32i_ctrl_alu_dmem_pkg::*;
#(
  parameter int DATA_WIDTH = rv32i_ctrl_alu_dmem_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = rv32i_ctrl_alu_dmem_pkg::ADDR_WIDTH,
  parameter int DEPTH      = rv32i_ctrl_alu_dmem_pkg::DEPTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  rv32i_ctrl_alu_dmem_if.slave   bus_io
);

  localparam int WAW = $clog2(DEPTH);

  ctrl_t                 ctrl_dec;
  ctrl_t                 ctrl;
  logic [DATA_WIDTH-1:0] b_opnd;
  logic [DATA_WIDTH-1:0] alu_res;
  logic [4:0]            shamt;
  logic                  alu_zero;
  logic                  br_taken;
  logic                  mem_we;
  logic [WAW-1:0]        mem_waddr;
  logic [DATA_WIDTH-1:0] mem_wdat;
  logic [3:0]            mem_be;
  logic [DATA_WIDTH-1:0] mem_rd;
  logic                  unused_bits;

  always_comb begin
    ctrl_dec          = '0;
    ctrl_dec.alu_ctrl = ALU_ADD;
    case (bus_io.opcode)
      OP_R: begin
        ctrl_dec.reg_write = 1'b1;
        ctrl_dec.wb_src    = WB_ALU;
        ctrl_dec.alu_ctrl  = alu_decode(bus_io.func3, bus_io.func7[5], 1'b1);
      end
      OP_I: begin
        ctrl_dec.reg_write = 1'b1;
        ctrl_dec.alu_src   = 1'b1;
        ctrl_dec.wb_src    = WB_ALU;
        ctrl_dec.imm_src   = IMM_I;
        ctrl_dec.alu_ctrl  = alu_decode(bus_io.func3, bus_io.func7[5], 1'b0);
      end
      OP_LOAD: begin
        ctrl_dec.mem_read  = 1'b1;
        ctrl_dec.mem_2_reg = 1'b1;
        ctrl_dec.reg_write = 1'b1;
        ctrl_dec.alu_src   = 1'b1;
        ctrl_dec.wb_src    = WB_MEM;
        ctrl_dec.imm_src   = IMM_I;
      end
      OP_STORE: begin
        ctrl_dec.mem_write = 1'b1;
        ctrl_dec.alu_src   = 1'b1;
        ctrl_dec.imm_src   = IMM_S;
      end
      OP_BRANCH: begin
        ctrl_dec.cond_br  = 1'b1;
        ctrl_dec.imm_src  = IMM_B;
        ctrl_dec.alu_ctrl = branch_alu(bus_io.func3);
      end
      OP_JAL: begin
        ctrl_dec.jump      = 1'b1;
        ctrl_dec.reg_write = 1'b1;
        ctrl_dec.wb_src    = WB_PC4;
        ctrl_dec.imm_src   = IMM_J;
      end
      OP_JALR: begin
        ctrl_dec.jump      = 1'b1;
        ctrl_dec.reg_write = 1'b1;
        ctrl_dec.alu_src   = 1'b1;
        ctrl_dec.wb_src    = WB_PC4;
        ctrl_dec.imm_src   = IMM_I;
        ctrl_dec.sec_src   = SEC_AS_JALR;
      end
      OP_LUI: begin
        ctrl_dec.reg_write = 1'b1;
        ctrl_dec.wb_src    = WB_U;
        ctrl_dec.imm_src   = IMM_U;
        ctrl_dec.sec_src   = SEC_AS_LUI;
      end
      OP_AUIPC: begin
        ctrl_dec.reg_write = 1'b1;
        ctrl_dec.wb_src    = WB_U;
        ctrl_dec.imm_src   = IMM_U;
        ctrl_dec.sec_src   = SEC_AS_AUIPC;
      end
      default: ;
    endcase
  end

  // Reset forces a NOP, which also blocks core stores and load data.
  assign ctrl = rst_n ? ctrl_dec : '0;

  assign b_opnd = ctrl.alu_src ? bus_io.imm : bus_io.rs2;
  assign shamt  = b_opnd[4:0];

  always_comb begin
    alu_res = '0;
    case (ctrl.alu_ctrl)
      ALU_ADD:  alu_res = bus_io.rs1 + b_opnd;
      ALU_SUB:  alu_res = bus_io.rs1 - b_opnd;
      ALU_AND:  alu_res = bus_io.rs1 & b_opnd;
      ALU_OR:   alu_res = bus_io.rs1 | b_opnd;
      ALU_XOR:  alu_res = bus_io.rs1 ^ b_opnd;
      ALU_SLL:  alu_res = bus_io.rs1 << shamt;
      ALU_SRL:  alu_res = bus_io.rs1 >> shamt;
      ALU_SRA:  alu_res = $unsigned($signed(bus_io.rs1) >>> shamt);
      ALU_SLT:  alu_res = {{(DATA_WIDTH-1){1'b0}}, $signed(bus_io.rs1) < $signed(b_opnd)};
      ALU_SLTU: alu_res = {{(DATA_WIDTH-1){1'b0}}, bus_io.rs1 < b_opnd};
      default:  alu_res = '0;
    endcase
  end

  assign alu_zero = (alu_res == '0);

  // func3[0] inverts the sense: BNE/BGE/BGEU are the complements of BEQ/BLT/BLTU.
  always_comb begin
    br_taken = 1'b0;
    case (bus_io.func3)
      3'b000:         br_taken = alu_zero;
      3'b001:         br_taken = !alu_zero;
      3'b100, 3'b110: br_taken = alu_res[0];
      3'b101, 3'b111: br_taken = !alu_res[0];
      default:        br_taken = 1'b0;
    endcase
  end

  assign mem_we    = rst_n & (bus_io.init_done ? ctrl.mem_write : bus_io.h_w_enb);
  assign mem_waddr = bus_io.init_done ? alu_res[ADDR_WIDTH-1:2] : bus_io.h_w_addr[ADDR_WIDTH-1:2];
  assign mem_wdat  = bus_io.init_done ? bus_io.rs2 : bus_io.h_w_dat;
  assign mem_be    = bus_io.init_done ? bus_io.byte_enb : bus_io.h_byte_enb;

  bram32_be #(
    .DW    (DATA_WIDTH),
    .DEPTH (DEPTH),
    .AW    (WAW)
  ) u_bram (
    .clk        (clk),
    .we_i       (mem_we),
    .be_i       (mem_be),
    .waddr_i    (mem_waddr),
    .wdat_i     (mem_wdat),
    .raddr_i    (alu_res[ADDR_WIDTH-1:2]),
    .rdat_o     (mem_rd),
    .dbg_addr_i (bus_io.debug_addr[ADDR_WIDTH-1:2]),
    .dbg_dat_o  (bus_io.debug_data)
  );

  assign bus_io.branch         = ctrl.jump | (ctrl.cond_br & br_taken);
  assign bus_io.imm_src        = ctrl.imm_src;
  assign bus_io.mem_read       = ctrl.mem_read;
  assign bus_io.mem_write      = ctrl.mem_write;
  assign bus_io.alu_src        = ctrl.alu_src;
  assign bus_io.reg_write      = ctrl.reg_write;
  assign bus_io.mem_2_reg      = ctrl.mem_2_reg;
  assign bus_io.wrt_back_src   = ctrl.wb_src;
  assign bus_io.second_add_src = ctrl.sec_src;
  assign bus_io.alu_result     = alu_res;
  assign bus_io.alu_zero       = alu_zero;
  assign bus_io.mem_rdata      = ctrl.mem_read ? mem_rd : '0;

  assign unused_bits = ^{bus_io.func7[6], bus_io.func7[4:0],
                         bus_io.h_w_addr[1:0], bus_io.debug_addr[1:0]};

endmodule

// File: tb/tb_rv32i_ctrl_alu_dmem.sv
// Directed-vector bench: stimulus pushes expected values, a negedge monitor pops and compares.
module tb_rv32i_ctrl_alu_dmem;
  import rv32i_ctrl_alu_dmem_pkg::*;

  localparam int S_ALU = 0, S_ZERO = 1, S_BRANCH = 2, S_CTRL = 3, S_RDATA = 4, S_DEBUG = 5;

  logic clk = 1'b0;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  int          sel_q[$];
  logic [31:0] exp_q[$];
  string       name_q[$];

  rv32i_ctrl_alu_dmem_if bus();

  rv32i_ctrl_alu_dmem dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_io (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1);
  end

  function automatic logic [31:0] cv(input logic br, input logic [2:0] is, input logic mr,
                                     input logic mw, input logic as, input logic rw,
                                     input logic m2r, input logic [1:0] wb, input logic [1:0] sec);
    return {19'b0, br, is, mr, mw, as, rw, m2r, wb, sec};
  endfunction

  function automatic logic [31:0] actual(input int sel);
    case (sel)
      S_ALU:    return bus.alu_result;
      S_ZERO:   return {31'b0, bus.alu_zero};
      S_BRANCH: return {31'b0, bus.branch};
      S_CTRL:   return {19'b0, bus.branch, bus.imm_src, bus.mem_read, bus.mem_write, bus.alu_src,
                        bus.reg_write, bus.mem_2_reg, bus.wrt_back_src, bus.second_add_src};
      S_RDATA:  return bus.mem_rdata;
      default:  return bus.debug_data;
    endcase
  endfunction

  // Monitor: every negedge, compare all expectations queued for the current cycle.
  always @(negedge clk) begin
    while (sel_q.size() > 0) begin
      int          s;
      logic [31:0] e;
      logic [31:0] a;
      string       nm;
      s  = sel_q.pop_front();
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      a  = actual(s);
      n_tests++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL %s: got 0x%08h, required 0x%08h", nm, a, e);
      end
    end
  end

  task automatic expect_v(input int sel, input logic [31:0] v, input string nm);
    sel_q.push_back(sel);
    exp_q.push_back(v);
    name_q.push_back(nm);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] im,
                        input logic [3:0] be);
    bus.opcode   = op;
    bus.func3    = f3;
    bus.func7    = f7;
    bus.rs1      = a;
    bus.rs2      = b;
    bus.imm      = im;
    bus.byte_enb = be;
  endtask

  task automatic dbg(input logic [11:0] addr, input logic [31:0] v, input string nm);
    bus.debug_addr = addr;
    expect_v(S_DEBUG, v, nm);
    tick();
  endtask

  logic [31:0] host_words [4];

  initial begin
    host_words[0] = 32'hDEADBEEF;
    host_words[1] = 32'h11223344;
    host_words[2] = 32'hCAFEF00D;
    host_words[3] = 32'h0BADF00D;

    rst_n          = 1'b0;
    bus.init_done  = 1'b0;
    bus.h_w_addr   = '0;
    bus.h_w_dat    = '0;
    bus.h_w_enb    = 1'b0;
    bus.h_byte_enb = '0;
    bus.debug_addr = '0;
    set_op(OP_LOAD, 3'b010, 7'h00, 32'h4, 32'h0, 32'h0, 4'h0);
    expect_v(S_CTRL,  32'h0, "reset_ctrl");
    expect_v(S_RDATA, 32'h0, "reset_rdata");
    tick();

    rst_n = 1'b1;
    set_op(7'h00, 3'b000, 7'h00, 32'h0, 32'h0, 32'h0, 4'h0);
    for (int i = 0; i < 4; i++) begin
      bus.h_w_enb    = 1'b1;
      bus.h_w_addr   = 12'(i * 4);
      bus.h_w_dat    = host_words[i];
      bus.h_byte_enb = 4'b1111;
      tick();
    end
    bus.h_w_enb   = 1'b0;
    bus.init_done = 1'b1;
    for (int i = 0; i < 4; i++) dbg(12'(i * 4), host_words[i], "host_init_word");

    bus.h_w_enb  = 1'b1;
    bus.h_w_addr = 12'h8;
    bus.h_w_dat  = 32'h0;
    tick();
    bus.h_w_enb = 1'b0;
    dbg(12'h8, 32'hCAFEF00D, "host_ignored_after_init");

    set_op(OP_STORE, 3'b010, 7'h00, 32'h0, 32'h8, 32'hC, 4'b1111);
    expect_v(S_CTRL, cv(0, 3'b001, 0, 1, 1, 0, 0, 2'b00, 2'b00), "sw_ctrl");
    expect_v(S_ALU,  32'hC, "sw_addr");
    tick();
    set_op(7'h00, 3'b000, 7'h00, 32'h0, 32'h0, 32'h0, 4'h0);
    dbg(12'hC, 32'h00000008, "sw_data");
    dbg(12'h8, 32'hCAFEF00D, "sw_neighbour");
    dbg(12'h0, 32'hDEADBEEF, "sw_word0");

    set_op(OP_STORE, 3'b000, 7'h00, 32'h0, 32'hAB00, 32'h4, 4'b0010);
    tick();
    set_op(7'h00, 3'b000, 7'h00, 32'h0, 32'h0, 32'h0, 4'h0);
    dbg(12'h4, 32'h1122AB44, "sb_lane1");

    set_op(OP_LOAD, 3'b010, 7'h00, 32'h4, 32'h0, 32'h0, 4'h0);
    expect_v(S_CTRL,  cv(0, 3'b000, 1, 0, 1, 1, 1, 2'b00, 2'b00), "lw_ctrl");
    expect_v(S_RDATA, 32'h1122AB44, "lw_rdata");
    tick();
    set_op(OP_LOAD, 3'b010, 7'h00, 32'h1000, 32'h0, 32'hC, 4'h0);
    expect_v(S_ALU,   32'h100C, "lw_wrap_addr");
    expect_v(S_RDATA, 32'h8, "lw_wrap_rdata");
    tick();

    set_op(OP_R, 3'b000, 7'h20, 32'd5, 32'd5, 32'h0, 4'h0);
    expect_v(S_ALU,  32'h0, "sub_result");
    expect_v(S_ZERO, 32'h1, "sub_zero");
    expect_v(S_CTRL, cv(0, 3'b000, 0, 0, 0, 1, 0, 2'b01, 2'b00), "r_ctrl");
    tick();
    set_op(OP_R, 3'b010, 7'h00, 32'hFFFFFFFF, 32'h1, 32'h0, 4'h0);
    expect_v(S_ALU, 32'h1, "slt_neg");
    tick();
    set_op(OP_R, 3'b011, 7'h00, 32'hFFFFFFFF, 32'h1, 32'h0, 4'h0);
    expect_v(S_ALU, 32'h0, "sltu_big");
    tick();
    set_op(OP_R, 3'b101, 7'h20, 32'h80000000, 32'h4, 32'h0, 4'h0);
    expect_v(S_ALU, 32'hF8000000, "sra");
    tick();
    set_op(OP_I, 3'b101, 7'h20, 32'h80000000, 32'h0, 32'h404, 4'h0);
    expect_v(S_ALU,  32'hF8000000, "srai");
    expect_v(S_CTRL, cv(0, 3'b000, 0, 0, 1, 1, 0, 2'b01, 2'b00), "i_ctrl");
    tick();
    set_op(OP_I, 3'b101, 7'h00, 32'h80000000, 32'h0, 32'h4, 4'h0);
    expect_v(S_ALU, 32'h08000000, "srli");
    tick();
    set_op(OP_I, 3'b000, 7'h20, 32'd10, 32'h0, 32'hFFFFFFFF, 4'h0);
    expect_v(S_ALU, 32'd9, "addi_not_sub");
    tick();

    set_op(OP_BRANCH, 3'b001, 7'h00, 32'd3, 32'd4, 32'h10, 4'h0);
    expect_v(S_ZERO, 32'h0, "bne_zero");
    expect_v(S_CTRL, cv(1, 3'b010, 0, 0, 0, 0, 0, 2'b00, 2'b00), "bne_ctrl");
    tick();
    set_op(OP_BRANCH, 3'b000, 7'h00, 32'd3, 32'd4, 32'h10, 4'h0);
    expect_v(S_BRANCH, 32'h0, "beq_not_taken");
    tick();
    set_op(OP_BRANCH, 3'b100, 7'h00, 32'hFFFFFFFF, 32'h1, 32'h10, 4'h0);
    expect_v(S_BRANCH, 32'h1, "blt_taken");
    tick();
    set_op(OP_BRANCH, 3'b110, 7'h00, 32'hFFFFFFFF, 32'h1, 32'h10, 4'h0);
    expect_v(S_BRANCH, 32'h0, "bltu_not_taken");
    tick();
    set_op(OP_BRANCH, 3'b111, 7'h00, 32'hFFFFFFFF, 32'h1, 32'h10, 4'h0);
    expect_v(S_BRANCH, 32'h1, "bgeu_taken");
    tick();

    set_op(OP_LUI, 3'b000, 7'h00, 32'h0, 32'h0, 32'h12345000, 4'h0);
    expect_v(S_CTRL, cv(0, 3'b100, 0, 0, 0, 1, 0, 2'b11, 2'b01), "lui_ctrl");
    tick();
    set_op(OP_AUIPC, 3'b000, 7'h00, 32'h0, 32'h0, 32'h12345000, 4'h0);
    expect_v(S_CTRL, cv(0, 3'b100, 0, 0, 0, 1, 0, 2'b11, 2'b10), "auipc_ctrl");
    tick();
    set_op(OP_JAL, 3'b000, 7'h00, 32'h0, 32'h0, 32'h100, 4'h0);
    expect_v(S_CTRL, cv(1, 3'b011, 0, 0, 0, 1, 0, 2'b10, 2'b00), "jal_ctrl");
    tick();
    set_op(OP_JALR, 3'b000, 7'h00, 32'h40, 32'h0, 32'h8, 4'h0);
    expect_v(S_BRANCH, 32'h1, "jalr_branch");
    tick();
    set_op(7'b1111111, 3'b000, 7'h00, 32'h5, 32'h5, 32'h0, 4'h0);
    expect_v(S_CTRL, 32'h0, "unknown_nop");
    tick();

    set_op(OP_LOAD, 3'b010, 7'h00, 32'h4, 32'h0, 32'h0, 4'h0);
    rst_n = 1'b0;
    bus.debug_addr = 12'hC;
    expect_v(S_CTRL,  32'h0, "midrun_reset_ctrl");
    expect_v(S_RDATA, 32'h0, "midrun_reset_rdata");
    expect_v(S_DEBUG, 32'h8, "debug_during_reset");
    tick();
    rst_n = 1'b1;
    expect_v(S_RDATA, 32'h1122AB44, "after_reset_lw");
    expect_v(S_CTRL,  cv(0, 3'b000, 1, 0, 1, 1, 1, 2'b00, 2'b00), "after_reset_ctrl");
    tick();
    set_op(7'h00, 3'b000, 7'h00, 32'h0, 32'h0, 32'h0, 4'h0);
    dbg(12'h0, 32'hDEADBEEF, "after_reset_word0");

    tick();
    if (sel_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d unchecked expectations, required 0", sel_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
